unidade_controle_jogo: RTL

- Moore FSM that sequences the ultimate tic-tac-toe datapath.
- Consumes the datapath status flags: tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT.
- Drives every datapath control strobe: register, RAM write, mux select, player toggle and timer.
- Sits directly beside the datapath at top level, with one clock domain shared with it.

---
 rtl/unidade_controle_jogo_if.sv | 36 +++
 rtl/unidade_controle_jogo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game control unit and the tic-tac-toe datapath.
interface unidade_controle_jogo_if;
  logic tem_jogada;
  logic macro_vencida;
  logic micro_jogada;
  logic fim_jogo;
  logic fimT;

  logic zeraEdge;
  logic zeraR_micro;
  logic zeraR_macro;
  logic zeraFlipFlopT;
  logic zeraT;
  logic registraR_micro;
  logic registraR_macro;
  logic sinal_macro;
  logic sinal_valida_macro;
  logic we_board;
  logic we_board_state;
  logic troca_jogador;
  logic contaT;

  modport master (
    input  tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
    output zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraT,
           registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
           we_board, we_board_state, troca_jogador, contaT
  );

  modport slave (
    output tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
    input  zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraT,
           registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
           we_board, we_board_state, troca_jogador, contaT
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the ultimate tic-tac-toe datapath.
// Optional per-turn idle timeout enabled by defining JOGADA_TIMEOUT_EN.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  unidade_controle_jogo_if.master dp,
  output logic                    pronto,
  output logic                    db_timeout,
  output logic [4:0]              db_estado
);

  typedef enum logic [4:0] {
    INICIAL        = 5'd0,
    PREPARA        = 5'd1,
    ESPERA_MACRO   = 5'd2,
    REGISTRA_MACRO = 5'd3,
    AGUARDA_MACRO  = 5'd4,
    VALIDA_MACRO   = 5'd5,
    ESPERA_MICRO   = 5'd6,
    REGISTRA_MICRO = 5'd7,
    AGUARDA_MICRO  = 5'd8,
    VALIDA_MICRO   = 5'd9,
    ESCREVE_BOARD  = 5'd10,
    AGUARDA_BOARD  = 5'd11,
    ESCREVE_STATE  = 5'd12,
    AGUARDA_STATE  = 5'd13,
    VERIFICA_FIM   = 5'd14,
    TROCA          = 5'd15,
    AGUARDA_PROX   = 5'd16,
    FIM            = 5'd17,
    PERDE_VEZ      = 5'd18
  } estado_t;

  estado_t state_reg, state_next;
  logic    timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= INICIAL;
    else        state_reg <= state_next;
  end

`ifdef JOGADA_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [CNT_W-1:0] cnt_reg;
  logic             em_espera;

  assign em_espera = (state_reg == ESPERA_MACRO) || (state_reg == ESPERA_MICRO);
  assign timeout   = em_espera && (cnt_reg == CNT_W'(TIMEOUT_CICLOS - 1));

  // Counter restarts only on entry to a wait-for-player state, not on its self-loop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else if ((state_next != state_reg) &&
             ((state_next == ESPERA_MACRO) || (state_next == ESPERA_MICRO)))
      cnt_reg <= '0;
    else if (em_espera)
      cnt_reg <= cnt_reg + 1'b1;
  end
`else
  assign timeout = 1'b0;
  if (TIMEOUT_CICLOS < 1) begin : g_timeout_invalido
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INICIAL:        if (iniciar) state_next = PREPARA;
      PREPARA:        state_next = ESPERA_MACRO;
      ESPERA_MACRO:   if (dp.tem_jogada) state_next = REGISTRA_MACRO;
                      else if (timeout) state_next = PERDE_VEZ;
      REGISTRA_MACRO: state_next = AGUARDA_MACRO;
      AGUARDA_MACRO:  if (dp.fimT) state_next = VALIDA_MACRO;
      VALIDA_MACRO:   state_next = dp.macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
      ESPERA_MICRO:   if (dp.tem_jogada) state_next = REGISTRA_MICRO;
                      else if (timeout) state_next = PERDE_VEZ;
      REGISTRA_MICRO: state_next = AGUARDA_MICRO;
      AGUARDA_MICRO:  if (dp.fimT) state_next = VALIDA_MICRO;
      VALIDA_MICRO:   state_next = dp.micro_jogada ? ESPERA_MICRO : ESCREVE_BOARD;
      ESCREVE_BOARD:  state_next = AGUARDA_BOARD;
      AGUARDA_BOARD:  if (dp.fimT) state_next = ESCREVE_STATE;
      ESCREVE_STATE:  state_next = AGUARDA_STATE;
      AGUARDA_STATE:  if (dp.fimT) state_next = VERIFICA_FIM;
      VERIFICA_FIM:   state_next = dp.fim_jogo ? FIM : TROCA;
      TROCA:          state_next = AGUARDA_PROX;
      AGUARDA_PROX:   if (dp.fimT) state_next = dp.macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
      FIM:            if (iniciar) state_next = PREPARA;
`ifdef JOGADA_TIMEOUT_EN
      PERDE_VEZ:      state_next = ESPERA_MACRO;
`endif
      default:        state_next = INICIAL;
    endcase
  end

  always_comb begin
    dp.zeraEdge           = 1'b0;
    dp.zeraR_micro        = 1'b0;
    dp.zeraR_macro        = 1'b0;
    dp.zeraFlipFlopT      = 1'b0;
    dp.zeraT              = 1'b0;
    dp.registraR_micro    = 1'b0;
    dp.registraR_macro    = 1'b0;
    dp.sinal_macro        = 1'b0;
    dp.sinal_valida_macro = 1'b0;
    dp.we_board           = 1'b0;
    dp.we_board_state     = 1'b0;
    dp.troca_jogador      = 1'b0;
    dp.contaT             = 1'b0;
    pronto                = 1'b0;
    db_timeout            = 1'b0;
    case (state_reg)
      PREPARA: begin
        dp.zeraEdge      = 1'b1;
        dp.zeraR_micro   = 1'b1;
        dp.zeraR_macro   = 1'b1;
        dp.zeraFlipFlopT = 1'b1;
        dp.zeraT         = 1'b1;
      end
      ESPERA_MACRO: begin
        dp.sinal_macro        = 1'b1;
        dp.sinal_valida_macro = 1'b1;
      end
      REGISTRA_MACRO: begin
        dp.registraR_macro = 1'b1;
        dp.sinal_macro     = 1'b1;
        dp.zeraT           = 1'b1;
      end
      AGUARDA_MACRO: begin
        dp.contaT             = 1'b1;
        dp.sinal_valida_macro = 1'b1;
      end
      VALIDA_MACRO: dp.sinal_valida_macro = 1'b1;
      REGISTRA_MICRO: begin
        dp.registraR_micro = 1'b1;
        dp.zeraT           = 1'b1;
      end
      AGUARDA_MICRO: dp.contaT = 1'b1;
      ESCREVE_BOARD: begin
        dp.we_board = 1'b1;
        dp.zeraT    = 1'b1;
      end
      AGUARDA_BOARD: dp.contaT = 1'b1;
      ESCREVE_STATE: begin
        dp.we_board_state     = 1'b1;
        dp.sinal_valida_macro = 1'b1;
        dp.zeraT              = 1'b1;
      end
      AGUARDA_STATE: dp.contaT = 1'b1;
      // Macro register reloads from the micro register: next board is the one just played.
      TROCA: begin
        dp.troca_jogador   = 1'b1;
        dp.registraR_macro = 1'b1;
        dp.zeraT           = 1'b1;
      end
      AGUARDA_PROX: begin
        dp.contaT             = 1'b1;
        dp.sinal_valida_macro = 1'b1;
      end
      FIM: pronto = 1'b1;
`ifdef JOGADA_TIMEOUT_EN
      PERDE_VEZ: begin
        dp.troca_jogador = 1'b1;
        db_timeout       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = state_reg;

endmodule
